iiitb_brg_frac: RTL

- Parametrised successor to the fixed 4-way baud rate generator.
- Derives an oversample tick, a bit tick and a 50% duty clkout from one system clock.
- Division is integer plus fractional, via a phase accumulator.
- Divisor comes from one of four preset parameters (sel) or from a runtime-programmable register loaded by a valid/ready handshake.
- Rate changes apply only on bit boundaries so clkout never glitches; the block feeds UART tx/rx engines.

---
 rtl/iiitb_brg_frac.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/iiitb_brg_frac.sv
// Fractional baud rate generator: phase-accumulator divider producing oversample tick,
// bit tick and a 50% duty bit clock, with preset or handshake-programmed divisors.
module iiitb_brg_frac #(
  parameter int unsigned      DIV_W   = 16,
  parameter int unsigned      FRAC_W  = 4,
  parameter int unsigned      OS      = 16,
  parameter logic [DIV_W-1:0] PRESET0 = DIV_W'(326),
  parameter logic [DIV_W-1:0] PRESET1 = DIV_W'(163),
  parameter logic [DIV_W-1:0] PRESET2 = DIV_W'(81),
  parameter logic [DIV_W-1:0] PRESET3 = DIV_W'(27)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [1:0]        sel,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_ready,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              clkout
);

  localparam int unsigned    OsW    = $clog2(OS);
  localparam logic [OsW-1:0] OsLast = OsW'(OS - 1);
  localparam logic [OsW-1:0] OsHalf = OsW'(OS / 2 - 1);

  logic [DIV_W-1:0]  prog_div_q, prog_div_d;
  logic [FRAC_W-1:0] prog_frac_q, prog_frac_d;
  logic [DIV_W-1:0]  act_div_q, act_div_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OsW-1:0]    os_cnt_q, os_cnt_d;
  logic              pending_q, pending_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_bit_q, tick_bit_d;
  logic              clkout_q, clkout_d;

  logic [DIV_W-1:0]  preset_div, tgt_raw, tgt_div, cur_div;
  logic [FRAC_W-1:0] tgt_frac, cur_frac, acc_sum;
  logic              carry, tick_evt, bit_evt, accept;

  always_comb begin
    preset_div = PRESET0;
    unique case (sel)
      2'd0: preset_div = PRESET0;
      2'd1: preset_div = PRESET1;
      2'd2: preset_div = PRESET2;
      2'd3: preset_div = PRESET3;
      default: preset_div = PRESET0;
    endcase
  end

  assign tgt_raw  = mode ? prog_div_q : preset_div;
  assign tgt_frac = mode ? prog_frac_q : '0;
  assign tgt_div  = (tgt_raw == '0) ? DIV_W'(1) : tgt_raw;

  assign tick_evt = en & (cnt_q == '0);
  assign bit_evt  = tick_evt & (os_cnt_q == OsLast);
  assign accept   = cfg_valid & ~pending_q;

  // On a bit boundary the period that starts now already uses the new target.
  assign cur_div  = bit_evt ? tgt_div : act_div_q;
  assign cur_frac = bit_evt ? tgt_frac : act_frac_q;
  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, cur_frac};

  always_comb begin
    prog_div_d  = accept ? cfg_div : prog_div_q;
    prog_frac_d = accept ? cfg_frac : prog_frac_q;

    pending_d = pending_q;
    if (!en || tick_bit_q) pending_d = 1'b0;
    if (accept)            pending_d = 1'b1;

    act_div_d  = act_div_q;
    act_frac_d = act_frac_q;
    cnt_d      = cnt_q - DIV_W'(1);
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    clkout_d   = clkout_q;

    if (!en) begin
      act_div_d  = tgt_div;
      act_frac_d = tgt_frac;
      cnt_d      = tgt_div - DIV_W'(1);
      acc_d      = '0;
      os_cnt_d   = '0;
      clkout_d   = 1'b0;
    end else if (tick_evt) begin
      tick_os_d  = 1'b1;
      tick_bit_d = bit_evt;
      if (bit_evt) begin
        act_div_d  = tgt_div;
        act_frac_d = tgt_frac;
      end
      // Fractional carry stretches the upcoming period by one cycle.
      cnt_d    = cur_div - DIV_W'(1) + {{(DIV_W - 1){1'b0}}, carry};
      acc_d    = acc_sum;
      os_cnt_d = bit_evt ? '0 : os_cnt_q + OsW'(1);
      if (bit_evt) begin
        clkout_d = 1'b1;
      end else if (os_cnt_q == OsHalf) begin
        clkout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_div_q  <= PRESET0;
      prog_frac_q <= '0;
      act_div_q   <= PRESET0;
      act_frac_q  <= '0;
      cnt_q       <= PRESET0 - DIV_W'(1);
      acc_q       <= '0;
      os_cnt_q    <= '0;
      pending_q   <= 1'b0;
      tick_os_q   <= 1'b0;
      tick_bit_q  <= 1'b0;
      clkout_q    <= 1'b0;
    end else begin
      prog_div_q  <= prog_div_d;
      prog_frac_q <= prog_frac_d;
      act_div_q   <= act_div_d;
      act_frac_q  <= act_frac_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      os_cnt_q    <= os_cnt_d;
      pending_q   <= pending_d;
      tick_os_q   <= tick_os_d;
      tick_bit_q  <= tick_bit_d;
      clkout_q    <= clkout_d;
    end
  end

  assign cfg_ready = ~pending_q;
  assign tick_os   = tick_os_q;
  assign tick_bit  = tick_bit_q;
  assign clkout    = clkout_q;

endmodule
